// File: rtl/aes_pkg.sv
// Shared AES definitions: block/byte widths, the state/key vector type and a byte-index helper.
// Used by add_round_key_buf and the neighbouring MixColumns/ShiftRows/SubBytes stages.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Byte 0 sits in the most significant byte of the block.
  function automatic logic [AES_BYTE_W-1:0] aes_byte(input aes_block_t blk, input int unsigned idx);
    return blk[AES_BLOCK_W-1-AES_BYTE_W*idx -: AES_BYTE_W];
  endfunction

endpackage

// File: rtl/add_round_key_buf_if.sv
// Data/key/status bundle for add_round_key_buf.
// The slave modport is the AddRoundKey stage; the master modport is its environment.
interface add_round_key_buf_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 3
);

  logic              flush;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              key_valid;
  logic [DATA_W-1:0] key_in;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              key_full;
  logic [CNT_W-1:0]  key_count;
  logic              err_underflow;
  logic              err_overflow;

  modport master (
    output flush, valid_in, data_in, key_valid, key_in,
    input  valid_out, data_out, key_full, key_count, err_underflow, err_overflow
  );

  modport slave (
    input  flush, valid_in, data_in, key_valid, key_in,
    output valid_out, data_out, key_full, key_count, err_underflow, err_overflow
  );

endinterface

// File: rtl/ark_key_fifo.sv
// Round-key queue for AddRoundKey: DEPTH x DATA_W registers with push/pop/flush and occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module ark_key_fifo #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/add_round_key_buf.sv
// AES-128 AddRoundKey with a round-key alignment FIFO and sticky misalignment flags.
// Optional macro ARK_KEY_BYPASS_EN: an empty FIFO forwards a same-cycle key straight to the XOR.
module add_round_key_buf
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W    = AES_BLOCK_W,
  parameter int unsigned KEY_DEPTH = 4,
  parameter int unsigned CNT_W     = $clog2(KEY_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  add_round_key_buf_if.slave    bus
);

  logic [DATA_W-1:0] head_key;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              pop, push, bypass, underflow, overflow;

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              err_unf_q, err_ovf_q;

`ifdef ARK_KEY_BYPASS_EN
  assign bypass = bus.valid_in & bus.key_valid & empty & ~bus.flush;
`else
  assign bypass = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a push is accepted even when full.
  assign pop       = bus.valid_in & ~empty & ~bus.flush;
  assign push      = bus.key_valid & ~bus.flush & ~bypass & (~full | pop);
  assign underflow = bus.valid_in & empty & ~bus.flush & ~bypass;
  assign overflow  = bus.key_valid & ~bus.flush & full & ~pop;

  ark_key_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (KEY_DEPTH),
    .CNT_W  (CNT_W)
  ) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.flush),
    .push  (push),
    .pop   (pop),
    .wdata (bus.key_in),
    .head  (head_key),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_unf_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q   <= 1'b0;
      err_unf_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      valid_q <= pop | bypass;
      if (pop) begin
        data_q <= bus.data_in ^ head_key;
      end else if (bypass) begin
        data_q <= bus.data_in ^ bus.key_in;
      end
      if (underflow) err_unf_q <= 1'b1;
      if (overflow)  err_ovf_q <= 1'b1;
    end
  end

  assign bus.valid_out     = valid_q;
  assign bus.data_out      = data_q;
  assign bus.key_full      = full;
  assign bus.key_count     = count;
  assign bus.err_underflow = err_unf_q;
  assign bus.err_overflow  = err_ovf_q;

endmodule

// File: tb/tb_add_round_key_buf.sv
// Directed bench for add_round_key_buf: reference key queue plus output scoreboard.
// Honours ARK_KEY_BYPASS_EN in the reference model when the macro is defined.
module tb_add_round_key_buf;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  add_round_key_buf_if #(.DATA_W(128), .CNT_W(3)) bus ();

  add_round_key_buf #(
    .DATA_W    (128),
    .KEY_DEPTH (4),
    .CNT_W     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  aes_block_t kq[$];
  aes_block_t sb[$];
  logic       m_vout, m_unf, m_ovf;
  aes_block_t m_dout;

  aes_block_t keys [4];
  aes_block_t zero_blk, ones_blk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("valid_out", 128'(bus.valid_out), 128'(m_vout));
    check("data_out", bus.data_out, m_dout);
    check("key_count", 128'(bus.key_count), 128'(kq.size()));
    check("key_full", 128'(bus.key_full), 128'(kq.size() == 4));
    check("err_underflow", 128'(bus.err_underflow), 128'(m_unf));
    check("err_overflow", 128'(bus.err_overflow), 128'(m_ovf));
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic step(input logic v, input aes_block_t d, input logic kv, input aes_block_t k,
                      input logic fl);
    int         cnt;
    logic       pop, push, byp;
    aes_block_t head;
    cnt = kq.size();
    byp = 1'b0;
`ifdef ARK_KEY_BYPASS_EN
    byp = v && kv && (cnt == 0) && !fl;
`endif
    pop  = v && (cnt != 0) && !fl;
    push = kv && !fl && !byp && ((cnt < 4) || pop);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.key_valid = kv;
    bus.key_in    = k;
    bus.flush     = fl;
    if (fl) begin
      kq.delete();
      m_unf  = 1'b0;
      m_ovf  = 1'b0;
      m_vout = 1'b0;
    end else begin
      m_vout = pop || byp;
      if (pop) begin
        head   = kq.pop_front();
        m_dout = d ^ head;
        sb.push_back(m_dout);
      end else if (byp) begin
        m_dout = d ^ k;
        sb.push_back(m_dout);
      end
      if (push) kq.push_back(k);
      if (v && (cnt == 0) && !byp) m_unf = 1'b1;
      if (kv && (cnt == 4) && !pop) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.valid_in  = 1'b0;
    bus.key_valid = 1'b0;
    bus.flush     = 1'b0;
    if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) check("unexpected_valid_out", 128'(bus.valid_out), 128'(0));
      else check("scoreboard", bus.data_out, sb.pop_front());
    end
    check_status();
  endtask

  task automatic idle();
    step(1'b0, zero_blk, 1'b0, zero_blk, 1'b0);
  endtask

  task automatic model_reset();
    kq.delete();
    sb.delete();
    m_vout = 1'b0;
    m_dout = '0;
    m_unf  = 1'b0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    zero_blk = '0;
    ones_blk = '1;
    keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    keys[1]  = 128'hdeadbeefcafebabe0123456789abcdef;
    keys[2]  = 128'h55aa55aa00ff00ff1234123456785678;
    keys[3]  = 128'hfedcba98765432100f1e2d3c4b5a6978;
    bus.flush = 1'b0; bus.valid_in = 1'b0; bus.key_valid = 1'b0;
    bus.data_in = '0; bus.key_in = '0;
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_status();
    @(negedge clk);
    reset = 1'b1;

    // 1: single key then a block one cycle later
    step(1'b0, zero_blk, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    step(1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, zero_blk, 1'b0);
    check("t1_data", bus.data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("t1_byte0", 128'(aes_byte(bus.data_out, 0)), 128'h a4);
    idle();

    // 2: fill then drain with zero blocks
    for (int i = 0; i < 4; i++) step(1'b0, zero_blk, 1'b1, keys[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, zero_blk, 1'b0, zero_blk, 1'b0);
      check("t2_order", bus.data_out, keys[i]);
    end
    idle();

    // 3: overflow drops the extra key
    for (int i = 0; i < 4; i++) step(1'b0, zero_blk, 1'b1, keys[i], 1'b0);
    step(1'b0, zero_blk, 1'b1, ones_blk, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, zero_blk, 1'b0, zero_blk, 1'b0);
    step(1'b0, zero_blk, 1'b0, zero_blk, 1'b1);

    // 4: push with pop while full, pointers wrap
    for (int i = 0; i < 4; i++) step(1'b0, zero_blk, 1'b1, keys[i], 1'b0);
    step(1'b1, ones_blk, 1'b1, ones_blk, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 128'h0f0f0f0f, 1'b0, zero_blk, 1'b0);

    // 5: empty FIFO with data and key together
    step(1'b1, zero_blk, 1'b1, ones_blk, 1'b0);
    idle();
    step(1'b0, zero_blk, 1'b0, zero_blk, 1'b1);

    // 6: flags set, two keys queued, flush ignores same-cycle inputs, then async reset
    step(1'b1, zero_blk, 1'b0, zero_blk, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, zero_blk, 1'b1, keys[i], 1'b0);
    step(1'b0, zero_blk, 1'b1, ones_blk, 1'b0);
    step(1'b1, zero_blk, 1'b0, zero_blk, 1'b0);
    step(1'b1, zero_blk, 1'b0, zero_blk, 1'b0);
    step(1'b1, ones_blk, 1'b1, ones_blk, 1'b1);
    step(1'b0, zero_blk, 1'b1, keys[2], 1'b0);
    step(1'b0, zero_blk, 1'b1, keys[3], 1'b0);
    bus.valid_in = 1'b1;
    bus.data_in  = ones_blk;
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_status();
    bus.valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    step(1'b1, zero_blk, 1'b0, zero_blk, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
